nbit_adder: RTL and testbench

Parameterised two-operand binary adder with a registered result. Built as an explicit ripple-carry chain of one-bit full adders. Captures operands on a valid strobe and presents the sum, carry-out and signed overflow one clock later. Serves as the general-purpose integer add stage in datapaths. Default width is 32 bits.

---
 rtl/nbit_adder_pkg.sv | 7 +
 rtl/nbit_adder_full_adder.sv | 21 ++
 rtl/nbit_adder.sv | 60 ++++++
 tb/tb_nbit_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nbit_adder_pkg.sv
// Shared constants for the ripple-carry adder stage.
package nbit_adder_pkg;

    // Operand/result width used when the instantiating datapath does not override it.
    localparam int unsigned ADDER_WIDTH_DEFAULT = 32;

endpackage : nbit_adder_pkg

// File: rtl/nbit_adder_full_adder.sv
// One-bit full adder: the building block of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic prop;

    // Propagate term shared by sum and carry.
    assign prop = a ^ b;

    // Sum bit.
    assign s = prop ^ cin;

    // Carry generated locally or propagated from below.
    assign cout = (a & b) | (cin & prop);

endmodule : full_adder

// File: rtl/nbit_adder.sv
// Registered two-operand adder built from an explicit ripple-carry chain.
// Produces sum (mod 2^WIDTH), unsigned carry-out and signed overflow one
// clock after a valid strobe; flags hold their value while idle.
module nbit_adder
    import nbit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;

    // The chain always starts with no carry in.
    assign carry[0] = 1'b0;

    // Ripple-carry chain: each stage's carry-out feeds the next stage's carry-in.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        full_adder u_fa (
            .a    (input1[i]),
            .b    (input2[i]),
            .cin  (carry[i]),
            .s    (sum_c[i]),
            .cout (carry[i+1])
        );
    end

    // Signed overflow: like-signed operands whose sum flips sign.
    assign ovf_c = (input1[MSB] == input2[MSB]) && (sum_c[MSB] != input1[MSB]);

    // Output stage: capture on valid, hold data otherwise; valid is a one-cycle pulse per capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= sum_c;
                carry_out <= carry[WIDTH];
                overflow  <= ovf_c;
            end
        end
    end

endmodule : nbit_adder

// File: tb/tb_nbit_adder.sv
// Bench for nbit_adder at WIDTH 32, 8 and 1 against an arithmetic reference model.
module tb_nbit_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cmp_on = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    logic        v32, c32, o32, ov32;
    logic [31:0] a32, b32, r32;
    logic        v8, c8, o8, ov8;
    logic [7:0]  a8, b8, r8;
    logic        v1, c1, o1, ov1;
    logic [0:0]  a1, b1, r1;

    nbit_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .input1(a32), .input2(b32),
        .result(r32), .carry_out(c32), .overflow(o32), .out_valid(ov32)
    );

    nbit_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .input1(a8), .input2(b8),
        .result(r8), .carry_out(c8), .overflow(o8), .out_valid(ov8)
    );

    nbit_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .input1(a1), .input2(b1),
        .result(r1), .carry_out(c1), .overflow(o1), .out_valid(ov1)
    );

    // Reference: true integer sum, then reduce to WIDTH bits and range-check the signed sum.
    function automatic void ref_add(input longint unsigned a, input longint unsigned b,
                                    input int w, output longint unsigned s,
                                    output bit c, output bit o);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned half = 64'd1 << (w - 1);
        longint unsigned full = (a & mask) + (b & mask);
        longint sa, sb, ss;
        sa = ((a & mask) >= half) ? longint'(a & mask) - longint'(64'd1 << w) : longint'(a & mask);
        sb = ((b & mask) >= half) ? longint'(b & mask) - longint'(64'd1 << w) : longint'(b & mask);
        ss = sa + sb;
        s  = full & mask;
        c  = ((full >> w) & 64'd1) != 64'd0;
        o  = (ss >= longint'(half)) || (ss < -longint'(half));
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    longint unsigned m32_s, m8_s, m1_s;
    bit m32_c, m32_o, m32_v, m8_c, m8_o, m8_v, m1_c, m1_o, m1_v;

    // Model state for each width, updated at the same edges as the DUTs.
    always @(posedge clk or negedge rst_n) begin : mdl
        longint unsigned s;
        bit c, o;
        if (!rst_n) begin
            m32_s <= 0; m32_c <= 0; m32_o <= 0; m32_v <= 0;
            m8_s  <= 0; m8_c  <= 0; m8_o  <= 0; m8_v  <= 0;
            m1_s  <= 0; m1_c  <= 0; m1_o  <= 0; m1_v  <= 0;
        end else begin
            m32_v <= v32;
            m8_v  <= v8;
            m1_v  <= v1;
            if (v32) begin
                ref_add(64'(a32), 64'(b32), 32, s, c, o);
                m32_s <= s; m32_c <= c; m32_o <= o;
            end
            if (v8) begin
                ref_add(64'(a8), 64'(b8), 8, s, c, o);
                m8_s <= s; m8_c <= c; m8_o <= o;
            end
            if (v1) begin
                ref_add(64'(a1), 64'(b1), 1, s, c, o);
                m1_s <= s; m1_c <= c; m1_o <= o;
            end
        end
    end

    // Every cycle, compare all outputs of all instances against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("res32", 64'(r32), m32_s);  chk("cout32", 64'(c32), 64'(m32_c));
            chk("ovf32", 64'(o32), 64'(m32_o)); chk("vld32", 64'(ov32), 64'(m32_v));
            chk("res8", 64'(r8), m8_s);     chk("cout8", 64'(c8), 64'(m8_c));
            chk("ovf8", 64'(o8), 64'(m8_o));    chk("vld8", 64'(ov8), 64'(m8_v));
            chk("res1", 64'(r1), m1_s);     chk("cout1", 64'(c1), 64'(m1_c));
            chk("ovf1", 64'(o1), 64'(m1_o));    chk("vld1", 64'(ov1), 64'(m1_v));
        end
    end

    function automatic logic [31:0] pick32();
        case ($urandom % 8)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_all(input bit force_valid);
        v32 = force_valid || (($urandom % 4) != 0);
        v8  = force_valid || (($urandom % 4) != 0);
        v1  = force_valid || (($urandom % 4) != 0);
        a32 = pick32(); b32 = pick32();
        a8  = 8'($urandom); b8 = 8'($urandom);
        a1  = 1'($urandom); b1 = 1'($urandom);
    endtask

    // Drive the 32-bit instance for one cycle; on return, outputs show the previous drive.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        v32 = v; a32 = a; b32 = b;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_r32"}, 64'(r32), 0); chk({name, "_v32"}, 64'(ov32), 0);
        chk({name, "_c32"}, 64'(c32), 0); chk({name, "_o32"}, 64'(o32), 0);
        chk({name, "_r8"},  64'(r8), 0);  chk({name, "_v8"},  64'(ov8), 0);
        chk({name, "_r1"},  64'(r1), 0);  chk({name, "_v1"},  64'(ov1), 0);
    endtask

    task automatic lit(input string name, input longint unsigned r, input bit c, input bit o, input bit v);
        chk({name, "_res"},  64'(r32), r);
        chk({name, "_cout"}, 64'(c32), 64'(c));
        chk({name, "_ovf"},  64'(o32), 64'(o));
        chk({name, "_vld"},  64'(ov32), 64'(v));
    endtask

    initial begin
        rand_all(1'b1);
        #1 rst_n = 1'b0;
        // Reset held with valid traffic present: everything stays cleared.
        repeat (3) begin
            @(negedge clk);
            rand_all(1'b1);
            chk_zero("rst_hold");
        end
        @(negedge clk);
        v32 = 0; v8 = 0; v1 = 0;
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Back-to-back basic sums.
        drive(1, 32'd129, 32'd1055);
        drive(1, 32'd220, 32'd20);
        lit("sum_a", 1184, 0, 0, 1);
        drive(1, 32'd100, 32'd30);
        lit("sum_b", 240, 0, 0, 1);
        drive(1, 32'd50, 32'hFFFF_FFF6);
        lit("sum_c", 130, 0, 0, 1);
        drive(1, 32'hFFFF_FFFF, 32'd1);
        lit("signed", 40, 1, 0, 1);
        drive(1, 32'h7FFF_FFFF, 32'd1);
        lit("wrap", 0, 1, 0, 1);
        drive(1, 32'h8000_0000, 32'h8000_0000);
        lit("posovf", 64'h8000_0000, 0, 1, 1);
        drive(1, 32'd220, 32'd20);
        lit("negovf", 0, 1, 1, 1);

        // Hold: idle cycles with changing operands leave data untouched.
        drive(0, $urandom, $urandom);
        lit("hold0", 240, 0, 0, 1);
        drive(0, $urandom, $urandom);
        lit("hold1", 240, 0, 0, 0);
        drive(0, $urandom, $urandom);
        lit("hold2", 240, 0, 0, 0);
        drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lit("hold3", 240, 0, 0, 0);

        // Randomized traffic on all widths, with an asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rand_all(1'b0);
            if (i == 300) begin
                v32 = 1; v8 = 1; v1 = 1;
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 chk_zero("async_rst");
                @(negedge clk);
                rand_all(1'b1);
                @(negedge clk);
                chk_zero("rst_mid_hold");
                rand_all(1'b0);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        v32 = 0; v8 = 0; v1 = 0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nbit_adder
